pipe_stage_buffer: RTL

- Parametrised elastic pipeline register placed between any two pipeline stages (decode→execute, execute→memory-access, memory-access→write-back); carries the packed stage struct as an opaque WIDTH-bit payload.
- Replaces the plain stage flop with a DEPTH-entry circular buffer and valid/ready handshakes on both sides.
- Whole-buffer flush for branch-mispredict redirect.
- in_ready is driven from buffer state only; it has no combinational path from out_ready, so stall timing is cut at every stage.

---
 rtl/pipe_stage_buffer_if.sv | 35 +++
 rtl/pipe_stage_buffer.sv | 68 ++++++
 2 files changed

// File: rtl/pipe_stage_buffer_if.sv
// Handshake bundle for pipe_stage_buffer.
//   slave  : the buffer side (takes in_*, flush, out_ready; drives the rest)
//   master : the stage/driver side (mirror image of slave)
// Signals:
//   flush            whole-buffer discard (branch-mispredict redirect)
//   in_valid/ready   upstream handshake, in_data payload
//   out_valid/ready  downstream handshake, out_data head payload
//   count/full/empty occupancy status
interface pipe_stage_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, full, empty
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, full, empty
  );
endinterface

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline register between two stages: DEPTH-entry circular buffer
// carrying an opaque WIDTH-bit stage payload, with valid/ready on both sides
// and a whole-buffer flush.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (pointers and occupancy only)
//   bus  pipe_stage_buffer_if.slave (handshakes, payloads, flush, status)
// in_ready depends only on buffer state (plus rst/flush), never on out_ready,
// so a downstream stall does not ripple combinationally upstream. The cost is
// that a full buffer cannot push and pop in the same cycle.
module pipe_stage_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CAP  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // rst and flush gate both handshakes, so no transfer can complete in a
  // cycle whose state is being thrown away.
  assign bus.in_ready  = !rst && !bus.flush && (cnt < CAP);
  assign bus.out_valid = !rst && !bus.flush && (cnt != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = cnt;
  assign bus.full      = (cnt == CAP);
  assign bus.empty     = (cnt == '0);

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage is never reset; entries are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end
endmodule
